// File: rtl/interrupt_controller.sv
// interrupt_controller: owns IF/IE, latches peripheral requests and completes the CPU dispatch handshake.
// Optional macro IRQ_EDGE_DETECT_EN: capture requests on rising edges instead of levels.
module interrupt_controller #(
    parameter logic [15:0] IF_ADDR     = 16'hFF0F,
    parameter logic [15:0] IE_ADDR     = 16'hFFFF,
    parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Enable,
    input  logic [15:0] i_Address,
    input  logic [7:0]  i_Bus,
    input  logic        i_Bus_Out,
    input  logic        i_Bus_In,
    output logic [7:0]  o_Bus,
    output logic        o_Selected,
    input  logic [4:0]  i_Requests,
    output logic [4:0]  o_Interrupts,
    input  logic        i_Handle_Interrupt,
    output logic [15:0] o_Vector,
    output logic        o_Vector_Valid,
    output logic        o_Wake
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t     state;
    logic [4:0] if_q;
    logic [7:0] ie_q;
    logic [4:0] new_req;
    logic [4:0] pending;
    logic [4:0] lowest;
    logic [4:0] ack_clear;
    logic [2:0] idx;
    logic       sel_if;
    logic       sel_ie;
    logic       dispatch;

    assign sel_if       = i_Address == IF_ADDR;
    assign sel_ie       = i_Address == IE_ADDR;
    assign o_Selected   = sel_if | sel_ie;
    assign o_Bus        = !i_Bus_In ? 8'h00 : sel_if ? {3'b111, if_q} : sel_ie ? ie_q : 8'h00;
    assign pending      = if_q & ie_q[4:0];
    assign o_Interrupts = pending;
    assign o_Wake       = |pending;

    // Lowest set bit wins: isolate it for the clear, encode it for the vector.
    assign dispatch  = state == IDLE && i_Handle_Interrupt;
    assign lowest    = pending & (~pending + 5'd1);
    assign ack_clear = dispatch ? lowest : 5'd0;
    assign idx       = pending[0] ? 3'd0 : pending[1] ? 3'd1 : pending[2] ? 3'd2 :
                       pending[3] ? 3'd3 : 3'd4;

`ifdef IRQ_EDGE_DETECT_EN
    logic [4:0] req_hist;

    always_ff @(posedge i_Clk or negedge i_Rst_n)
        if (!i_Rst_n)
            req_hist <= 5'd0;
        else if (i_Enable)
            req_hist <= i_Requests;

    assign new_req = i_Requests & ~req_hist;
`else
    assign new_req = i_Requests;
`endif

    // New requests beat the dispatch clear, which beats the CPU write.
    always_ff @(posedge i_Clk or negedge i_Rst_n)
        if (!i_Rst_n) begin
            if_q <= 5'd0;
            ie_q <= 8'd0;
        end else if (i_Enable) begin
            if_q <= (((i_Bus_Out && sel_if) ? i_Bus[4:0] : if_q) & ~ack_clear) | new_req;
            if (i_Bus_Out && sel_ie)
                ie_q <= i_Bus;
        end

    always_ff @(posedge i_Clk or negedge i_Rst_n)
        if (!i_Rst_n) begin
            state          <= IDLE;
            o_Vector       <= 16'h0000;
            o_Vector_Valid <= 1'b0;
        end else if (i_Enable) begin
            case (state)
                IDLE:
                    if (i_Handle_Interrupt) begin
                        state          <= ACK;
                        o_Vector_Valid <= 1'b1;
                        o_Vector       <= |pending ? VECTOR_BASE + {10'd0, idx, 3'd0} : 16'h0000;
                    end
                ACK:
                    if (!i_Handle_Interrupt) begin
                        state          <= IDLE;
                        o_Vector_Valid <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed vector table, hand sequences and randomized run against a reference model.
module tb_interrupt_controller;
`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam logic [15:0] F = 16'hFF0F;
    localparam logic [15:0] E = 16'hFFFF;
    localparam logic [15:0] C = 16'hC000;

    logic        i_Clk;
    logic        i_Rst_n;
    logic        i_Enable;
    logic [15:0] i_Address;
    logic [7:0]  i_Bus;
    logic        i_Bus_Out;
    logic        i_Bus_In;
    logic [7:0]  o_Bus;
    logic        o_Selected;
    logic [4:0]  i_Requests;
    logic [4:0]  o_Interrupts;
    logic        i_Handle_Interrupt;
    logic [15:0] o_Vector;
    logic        o_Vector_Valid;
    logic        o_Wake;

    interrupt_controller dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Enable(i_Enable), .i_Address(i_Address),
        .i_Bus(i_Bus), .i_Bus_Out(i_Bus_Out), .i_Bus_In(i_Bus_In), .o_Bus(o_Bus),
        .o_Selected(o_Selected), .i_Requests(i_Requests), .o_Interrupts(o_Interrupts),
        .i_Handle_Interrupt(i_Handle_Interrupt), .o_Vector(o_Vector),
        .o_Vector_Valid(o_Vector_Valid), .o_Wake(o_Wake)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        wr;
        logic        rd;
        logic [4:0]  req;
        logic        hi;
        logic [4:0]  e_int;
        logic [15:0] e_vec;
        logic        e_vv;
        logic [7:0]  e_bus;
    } vec_t;

    vec_t tv [24];
    int checks = 0;
    int errors = 0;

    logic [4:0]  m_if;
    logic [4:0]  m_hist;
    logic [7:0]  m_ie;
    bit          m_ack;
    logic [15:0] m_vec;
    bit          m_vv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_if = 0; m_hist = 0; m_ie = 0; m_ack = 0; m_vec = 0; m_vv = 0;
    endtask

    // Behavioural reference: applies the documented priority rules to the pre-edge state.
    task automatic model_step();
        logic [4:0] nr, clr, p, base;
        if (!i_Enable) return;
        nr  = EDGE ? (i_Requests & ~m_hist) : i_Requests;
        clr = 0;
        if (!m_ack && i_Handle_Interrupt) begin
            p = m_if & m_ie[4:0];
            m_vec = 16'h0000;
            for (int i = 0; i < 5; i++)
                if (p[i]) begin
                    clr   = 5'(1 << i);
                    m_vec = 16'h0040 + 16'(8 * i);
                    break;
                end
            m_vv = 1; m_ack = 1;
        end else if (m_ack && !i_Handle_Interrupt) begin
            m_vv = 0; m_ack = 0;
        end
        base = (i_Bus_Out && i_Address == F) ? i_Bus[4:0] : m_if;
        m_if = (base & ~clr) | nr;
        if (i_Bus_Out && i_Address == E) m_ie = i_Bus;
        m_hist = i_Requests;
    endtask

    function automatic logic [7:0] model_bus();
        if (!i_Bus_In) return 8'h00;
        if (i_Address == F) return {3'b111, m_if};
        if (i_Address == E) return m_ie;
        return 8'h00;
    endfunction

    task automatic drive(input logic en, input logic [15:0] addr, input logic [7:0] wd, input logic wr,
                         input logic rd, input logic [4:0] req, input logic hi);
        i_Enable = en; i_Address = addr; i_Bus = wd; i_Bus_Out = wr; i_Bus_In = rd;
        i_Requests = req; i_Handle_Interrupt = hi;
        @(posedge i_Clk);
        model_step();
        @(negedge i_Clk);
    endtask

    task automatic check_model(input string tag);
        logic [4:0] mi;
        mi = m_if & m_ie[4:0];
        chk({tag, " int"}, 32'(o_Interrupts), 32'(mi));
        chk({tag, " wake"}, 32'(o_Wake), 32'(|mi));
        chk({tag, " vec"}, 32'(o_Vector), 32'(m_vec));
        chk({tag, " vv"}, 32'(o_Vector_Valid), 32'(m_vv));
        chk({tag, " sel"}, 32'(o_Selected), 32'(i_Address == F || i_Address == E));
        chk({tag, " bus"}, 32'(o_Bus), 32'(model_bus()));
    endtask

    task automatic read_chk(input string name, input logic [15:0] addr, input logic [7:0] exp);
        i_Address = addr; i_Bus_In = 1'b1;
        #1;
        chk(name, 32'(o_Bus), 32'(exp));
        i_Bus_In = 1'b0; i_Address = C;
    endtask

    initial begin
        logic [4:0] ei;
        logic [7:0] eb;
        logic       hi;
        logic [15:0] ra;
        ei = EDGE ? 5'h00 : 5'h08;
        eb = EDGE ? 8'hE0 : 8'hE8;
        tv[0]  = '{1'b1, E, 8'h1F, 1'b1, 1'b1, 5'h00, 1'b0, 5'h00, 16'h0000, 1'b0, 8'h1F};
        tv[1]  = '{1'b1, F, 8'h00, 1'b0, 1'b1, 5'h04, 1'b0, 5'h04, 16'h0000, 1'b0, 8'hE4};
        tv[2]  = '{1'b1, F, 8'h00, 1'b0, 1'b1, 5'h00, 1'b0, 5'h04, 16'h0000, 1'b0, 8'hE4};
        tv[3]  = '{1'b1, F, 8'h16, 1'b1, 1'b1, 5'h00, 1'b0, 5'h16, 16'h0000, 1'b0, 8'hF6};
        tv[4]  = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b1, 5'h14, 16'h0048, 1'b1, 8'h00};
        tv[5]  = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b1, 5'h14, 16'h0048, 1'b1, 8'h00};
        tv[6]  = '{1'b1, F, 8'h00, 1'b0, 1'b1, 5'h00, 1'b1, 5'h14, 16'h0048, 1'b1, 8'hF4};
        tv[7]  = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0, 5'h14, 16'h0048, 1'b0, 8'h00};
        tv[8]  = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b1, 5'h10, 16'h0050, 1'b1, 8'h00};
        tv[9]  = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0, 5'h10, 16'h0050, 1'b0, 8'h00};
        tv[10] = '{1'b1, E, 8'h00, 1'b1, 1'b1, 5'h00, 1'b0, 5'h00, 16'h0050, 1'b0, 8'h00};
        tv[11] = '{1'b1, F, 8'h01, 1'b1, 1'b1, 5'h00, 1'b0, 5'h00, 16'h0050, 1'b0, 8'hE1};
        tv[12] = '{1'b1, F, 8'h00, 1'b0, 1'b1, 5'h00, 1'b1, 5'h00, 16'h0000, 1'b1, 8'hE1};
        tv[13] = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0, 5'h00, 16'h0000, 1'b0, 8'h00};
        tv[14] = '{1'b1, E, 8'h01, 1'b1, 1'b1, 5'h00, 1'b0, 5'h01, 16'h0000, 1'b0, 8'h01};
        tv[15] = '{1'b1, F, 8'h03, 1'b1, 1'b1, 5'h01, 1'b1, 5'h01, 16'h0040, 1'b1, 8'hE3};
        tv[16] = '{1'b1, F, 8'h00, 1'b0, 1'b1, 5'h00, 1'b0, 5'h01, 16'h0040, 1'b0, 8'hE3};
        tv[17] = '{1'b1, E, 8'hFF, 1'b1, 1'b1, 5'h00, 1'b0, 5'h03, 16'h0040, 1'b0, 8'hFF};
        tv[18] = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h08, 1'b0, 5'h0B, 16'h0040, 1'b0, 8'h00};
        tv[19] = '{1'b1, F, 8'h00, 1'b1, 1'b1, 5'h08, 1'b0, ei,    16'h0040, 1'b0, eb};
        tv[20] = '{1'b1, F, 8'h00, 1'b0, 1'b1, 5'h08, 1'b0, ei,    16'h0040, 1'b0, eb};
        tv[21] = '{1'b0, E, 8'h00, 1'b1, 1'b1, 5'h01, 1'b0, ei,    16'h0040, 1'b0, 8'hFF};
        tv[22] = '{1'b0, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b1, ei,    16'h0040, 1'b0, 8'h00};
        tv[23] = '{1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b0, ei,    16'h0040, 1'b0, 8'h00};

        i_Rst_n = 1'b0; i_Enable = 1'b1; i_Address = C; i_Bus = 0; i_Bus_Out = 0; i_Bus_In = 0;
        i_Requests = 0; i_Handle_Interrupt = 0;
        model_reset();
        repeat (2) @(negedge i_Clk);
        read_chk("rst IF", F, 8'hE0);
        read_chk("rst IE", E, 8'h00);
        read_chk("rst other", C, 8'h00);
        chk("rst int", 32'(o_Interrupts), 0);
        chk("rst wake", 32'(o_Wake), 0);
        chk("rst vv", 32'(o_Vector_Valid), 0);
        chk("rst vec", 32'(o_Vector), 0);
        chk("rst sel", 32'(o_Selected), 0);
        i_Rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            drive(tv[k].en, tv[k].addr, tv[k].wd, tv[k].wr, tv[k].rd, tv[k].req, tv[k].hi);
            chk($sformatf("tv%0d int", k), 32'(o_Interrupts), 32'(tv[k].e_int));
            chk($sformatf("tv%0d wake", k), 32'(o_Wake), 32'(|tv[k].e_int));
            chk($sformatf("tv%0d vec", k), 32'(o_Vector), 32'(tv[k].e_vec));
            chk($sformatf("tv%0d vv", k), 32'(o_Vector_Valid), 32'(tv[k].e_vv));
            chk($sformatf("tv%0d bus", k), 32'(o_Bus), 32'(tv[k].e_bus));
            chk($sformatf("tv%0d sel", k), 32'(o_Selected), 32'(tv[k].addr == F || tv[k].addr == E));
        end

        // Reset asserted while a dispatch is being held in ACK.
        drive(1'b1, E, 8'h1F, 1'b1, 1'b0, 5'h00, 1'b0);
        drive(1'b1, F, 8'h1E, 1'b1, 1'b0, 5'h00, 1'b0);
        drive(1'b1, C, 8'h00, 1'b0, 1'b0, 5'h00, 1'b1);
        chk("ack vec", 32'(o_Vector), 32'h0048);
        chk("ack vv", 32'(o_Vector_Valid), 1);
        #2 i_Rst_n = 1'b0;
        #1;
        chk("midrst vv", 32'(o_Vector_Valid), 0);
        chk("midrst vec", 32'(o_Vector), 0);
        chk("midrst int", 32'(o_Interrupts), 0);
        chk("midrst wake", 32'(o_Wake), 0);
        read_chk("midrst IF", F, 8'hE0);
        read_chk("midrst IE", E, 8'h00);
        i_Handle_Interrupt = 1'b0;
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        model_reset();

        hi = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0: ra = F;
                1: ra = E;
                2: ra = C;
                default: ra = 16'hFF0E;
            endcase
            if ($urandom_range(0, 3) == 0) hi = ~hi;
            drive($urandom_range(0, 7) != 0, ra, 8'($urandom), $urandom_range(0, 2) == 0,
                  1'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00, hi);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Memory-mapped responder that owns the IF (0xFF0F) and IE (0xFFFF) registers. It latches peripheral interrupt requests and presents the pending-and-enabled mask to the CPU's i_Interrupts input.
- Completes the CPU's interrupt dispatch handshake: it supplies the service vector and clears the serviced IF bit.
- Sits on the CPU memory bus beside RAM/IO responders; its read data is ORed onto the CPU's i_Bus with the other responders.

Parameters:
- IF_ADDR, 16'hFF0F, address of the interrupt flag register
- IE_ADDR, 16'hFFFF, address of the interrupt enable register
- VECTOR_BASE, 16'h0040, service vector of interrupt 0; vector n = VECTOR_BASE + 8*n

Ports:
- i_Clk  input  1  system clock
- i_Rst_n  input  1  asynchronous active-low reset
- i_Enable  input  1  clock enable; all state updates are gated by it
- i_Address  input  16  CPU o_Address
- i_Bus  input  8  CPU write data (CPU o_Bus)
- i_Bus_Out  input  1  CPU write strobe
- i_Bus_In  input  1  CPU read strobe
- o_Bus  output  8  read data; 8'h00 when not selected
- o_Selected  output  1  i_Address matches IF_ADDR or IE_ADDR
- i_Requests  input  5  peripheral requests: bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad
- o_Interrupts  output  5  IF & IE[4:0], to CPU i_Interrupts
- i_Handle_Interrupt  input  1  CPU o_Handle_Interrupt
- o_Vector  output  16  service vector address
- o_Vector_Valid  output  1  o_Vector is valid for the current dispatch
- o_Wake  output  1  |(IF & IE[4:0]); HALT exit, independent of IME

Behaviour:
- Reset (async, i_Rst_n low):
  - IF=0, IE=0, request history=0, state IDLE.
  - o_Vector=16'h0000, o_Vector_Valid=0.
  - o_Interrupts=0, o_Wake=0, o_Bus=0.
- Registers:
  - IF is 5 bits; reads return {3'b111, IF}.
  - IE is 8 bits; all bits are storable and read back; only IE[4:0] gate interrupts.
- Reads: combinational. o_Bus = register value when i_Bus_In and the address matches, else 8'h00.
- Writes: take effect at the clock edge when i_Enable & i_Bus_Out & address match; IF takes i_Bus[4:0].
- Request capture: new_req = per-bit request event (see Optional Feature). A request at edge n is visible in IF and o_Interrupts after edge n.
- IF next-state, in priority order (highest first):
  1. new_req sets.
  2. Dispatch clear clears.
  3. CPU write value.
  - Formula: IF_next = ((write ? i_Bus[4:0] : IF) & ~ack_clear) | new_req.
- o_Interrupts and o_Wake are combinational from the IF/IE registers.
- Dispatch FSM (advances only when i_Enable):
  - IDLE:
    - On i_Handle_Interrupt=1, sample P = IF & IE[4:0] at that edge.
    - If P!=0: idx = lowest set bit; ack_clear = onehot(idx) applied at this same edge; o_Vector = VECTOR_BASE + 8*idx; o_Vector_Valid=1; -> ACK.
    - If P==0 (cancelled dispatch): o_Vector = 16'h0000, o_Vector_Valid=1, no IF clear; -> ACK.
  - ACK:
    - Hold o_Vector and o_Vector_Valid while i_Handle_Interrupt=1.
    - Requests keep latching into IF; no further clear.
    - On i_Handle_Interrupt=0: o_Vector_Valid=0; o_Vector keeps its last value; -> IDLE.
  - One dispatch per assertion of i_Handle_Interrupt, regardless of its length.
- Boundary cases:
  - Request on the same bit at the dispatch edge: IF bit stays 1 (set wins).
  - CPU write to IF at the dispatch edge: the write value is applied, then the serviced bit is cleared.
  - Write to IE at the dispatch edge: does not affect the P already sampled.
  - i_Enable=0: state, IF, IE and history are frozen; combinational outputs still track the registers.
  - Reset mid-ACK: returns to IDLE immediately with the reset values above.

Optional Feature:
- Macro: IRQ_EDGE_DETECT_EN.
- Defined:
  - new_req = i_Requests & ~req_hist, where req_hist is registered i_Requests (updated when i_Enable).
  - A request held high sets IF once; software can clear it while the request stays high.
- Undefined:
  - new_req = i_Requests (level).
  - IF bit is re-set on every enabled edge while the request is high.
  - No history register.

Test Plan:
- Reset then read 0xFF0F and 0xFFFF -> 8'hE0 and 8'h00; o_Interrupts=0, o_Vector_Valid=0; o_Bus=0 at address 0xC000.
- Write IE=8'h1F; pulse i_Requests=5'b00100 for one cycle -> IF read 8'hE4; o_Interrupts=5'b00100; o_Wake=1.
- IF=5'b10110, IE=8'h1F; assert i_Handle_Interrupt for 3 cycles:
  - -> o_Vector=16'h0048, o_Vector_Valid=1 during the assertion, IF=5'b10100; one clear only.
  - Deassert, then reassert -> o_Vector=16'h0050.
- IF=5'b00001, IE=0; assert i_Handle_Interrupt -> o_Vector=16'h0000, o_Vector_Valid=1, IF unchanged 5'b00001.
- Dispatch of bit0 in the same cycle as i_Requests[0] rising (edge mode) and a CPU write IF=8'h03 -> o_Vector=16'h0040, IF=5'b00011.
- With IRQ_EDGE_DETECT_EN: hold i_Requests[3]=1, write IF=0 -> IF stays 0. Without the macro: IF[3]=1 on the next edge.
